// File: rtl/count_seq_ctrl_if.sv
// Control-side bundle between the CSR logic (master) and the count sequencer (slave).
//
// Handshake: start and stop are level requests sampled on every rising clk edge.
// busy is the ready indication. A start is accepted only in a cycle where
// busy == 0 and stop == 0, and mode/terminal are captured on that same edge.
// A start seen while busy is dropped and flagged on err one cycle later.
// done and err are single-cycle pulses. period_cnt is a level that stays valid
// until the next accepted start.
interface count_seq_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int PW    = 8
);
    logic             start;
    logic             stop;
    logic             mode;
    logic [WIDTH-1:0] terminal;
    logic             busy;
    logic             done;
    logic             err;
    logic [PW-1:0]    period_cnt;

    modport master (
        output start, stop, mode, terminal,
        input  busy, done, err, period_cnt
    );

    modport slave (
        input  start, stop, mode, terminal,
        output busy, done, err, period_cnt
    );
endinterface

// File: rtl/count_seq_ctrl.sv
// Sequencer for a WIDTH-bit up-counter with synchronous clear.
// It clears the counter, enables it up to a latched terminal value, and then
// either finishes (one-shot) or clears and restarts (auto-reload). It counts
// completed windows and flags protocol and datapath errors.
module count_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int PW    = 8
) (
    input  logic             clk,
    input  logic             reset_n,      // asynchronous, active-high despite the name
    count_seq_ctrl_if.slave  ctl,
    input  logic [WIDTH-1:0] cnt_val_i,
    output logic             cnt_clear_o,
    output logic             cnt_en_o,
    output logic [2:0]       state_o       // debug view of the FSM state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        RUN    = 3'd2,
        RELOAD = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] term_q;
    logic             mode_q;
    logic [PW-1:0]    period_q;
    logic             err_q;

    logic             busy;
    logic             at_term;
    logic             over_term;
    logic             err_d;

    assign busy      = (state_q != IDLE);
    assign at_term   = (cnt_val_i == term_q);
    assign over_term = (cnt_val_i > term_q);

    // A start while busy and a counter overrun share one pulse; an overrun that
    // coincides with stop is not flagged because the stop wins.
    assign err_d = (busy && ctl.start) ||
                   ((state_q == RUN) && !ctl.stop && over_term);

    // Main sequencer: state, latched window settings, window counter, error pulse.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state_q  <= IDLE;
            term_q   <= '0;
            mode_q   <= 1'b0;
            period_q <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= err_d;
            case (state_q)
                IDLE: begin
                    if (!ctl.stop && ctl.start) begin
                        term_q   <= ctl.terminal;
                        mode_q   <= ctl.mode;
                        period_q <= '0;
                        state_q  <= CLEAR;
                    end
                end
                CLEAR: begin
                    state_q <= ctl.stop ? IDLE : RUN;
                end
                RUN: begin
                    if (ctl.stop || over_term) begin
                        state_q <= IDLE;
                    end else if (at_term) begin
                        state_q <= mode_q ? RELOAD : DONE;
                    end
                end
                RELOAD: begin
                    // The window has already completed, so it is counted even if
                    // a stop arrives in this cycle.
                    period_q <= period_q + 1'b1;
                    state_q  <= ctl.stop ? IDLE : RUN;
                end
                DONE: begin
                    period_q <= period_q + 1'b1;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // The outputs come from the registered state. cnt_en also uses the RUN
    // compare, so the counter stops on the terminal value. cnt_clear is high
    // only in CLEAR and RELOAD, and cnt_en only in RUN, so they never overlap.
    assign cnt_clear_o    = (state_q == CLEAR) || (state_q == RELOAD);
    assign cnt_en_o       = (state_q == RUN) && !at_term;
    assign ctl.busy       = busy;
    assign ctl.done       = (state_q == RELOAD) || (state_q == DONE);
    assign ctl.err        = err_q;
    assign ctl.period_cnt = period_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Directed bench for count_seq_ctrl. Each instance drives a behavioural
// up-counter. A second instance with PW=2 mirrors the same stimulus so that
// the wrap of period_cnt can be observed.
module tb_count_seq_ctrl;

    logic       clk;
    logic       reset_n;
    logic [3:0] cnt1, cnt2;
    logic [3:0] cnt_val1;
    logic       force_en;
    logic [3:0] force_val;
    logic       clr1, en1, clr2, en2;
    logic [2:0] st1, st2;

    count_seq_ctrl_if #(.WIDTH(4), .PW(8)) if1 ();
    count_seq_ctrl_if #(.WIDTH(4), .PW(2)) if2 ();

    assign if2.start    = if1.start;
    assign if2.stop     = if1.stop;
    assign if2.mode     = if1.mode;
    assign if2.terminal = if1.terminal;

    count_seq_ctrl #(.WIDTH(4), .PW(8)) u_dut (
        .clk(clk), .reset_n(reset_n), .ctl(if1),
        .cnt_val_i(cnt_val1), .cnt_clear_o(clr1), .cnt_en_o(en1), .state_o(st1)
    );

    count_seq_ctrl #(.WIDTH(4), .PW(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .ctl(if2),
        .cnt_val_i(cnt2), .cnt_clear_o(clr2), .cnt_en_o(en2), .state_o(st2)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural counter datapaths (clear has priority over enable)
    always @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            cnt1 <= '0;
            cnt2 <= '0;
        end else begin
            if (clr1) cnt1 <= '0; else if (en1) cnt1 <= cnt1 + 4'd1;
            if (clr2) cnt2 <= '0; else if (en2) cnt2 <= cnt2 + 4'd1;
        end
    end
    assign cnt_val1 = force_en ? force_val : cnt1;

    // Scoreboard counters and event monitor (sampled mid-cycle)
    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int cyc = 0;
    int done_cnt, first_done, last_done;
    int en_cnt, first_en, last_en;
    int err_cnt;
    int both_cnt = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            if (if1.done) begin
                if (done_cnt == 0) first_done = cyc;
                last_done = cyc;
                done_cnt++;
            end
            if (en1) begin
                if (en_cnt == 0) first_en = cyc;
                last_en = cyc;
                en_cnt++;
            end
            if (if1.err) err_cnt++;
            if (clr1 && en1) both_cnt++;
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clr_mon();
        done_cnt = 0; first_done = 0; last_done = 0;
        en_cnt = 0; first_en = 0; last_en = 0;
        err_cnt = 0;
    endtask

    // Drives start for one edge (edge 0). Afterwards the bench is in cycle 1.
    // mode/terminal are then scrambled to show they are ignored while busy.
    task automatic start_win(input logic m, input logic [3:0] t);
        if1.mode     = m;
        if1.terminal = t;
        if1.start    = 1'b1;
        tick();
        if1.start    = 1'b0;
        if1.mode     = ~m;
        if1.terminal = ~t;
        cyc = 1;
    endtask

    task automatic wait_idle();
        while (if1.busy && cyc < 80) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (%0d/%0d checks passed so far)", passes, checks);
        $fatal(1, "watchdog");
    end

    // Directed stimulus
    initial begin
        reset_n = 1'b1;
        if1.start = 1'b0; if1.stop = 1'b0; if1.mode = 1'b0; if1.terminal = 4'd0;
        force_en = 1'b0; force_val = 4'd0;
        clr_mon();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", st1, 0);
        chk("rst_busy", if1.busy, 0);
        chk("rst_done", if1.done, 0);
        chk("rst_err", if1.err, 0);
        chk("rst_clear", clr1, 0);
        chk("rst_en", en1, 0);
        chk("rst_period", if1.period_cnt, 0);
        reset_n = 1'b0;
        tick();

        // T1: one-shot, terminal 5
        clr_mon();
        start_win(1'b0, 4'd5);
        chk("t1_clear_c1", clr1, 1);
        chk("t1_state_c1", st1, 1);
        wait_idle();
        chk("t1_idle_cycle", cyc, 9);
        chk("t1_first_en", first_en, 2);
        chk("t1_last_en", last_en, 6);
        chk("t1_en_cnt", en_cnt, 5);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_done_cycle", last_done, 8);
        chk("t1_period", if1.period_cnt, 1);

        // T2: auto-reload, terminal 3, with the PW=2 copy wrapping
        clr_mon();
        start_win(1'b1, 4'd3);
        while (done_cnt < 3 && cyc < 80) tick();
        chk("t2_cyc3", cyc, 17);
        chk("t2_period3", if1.period_cnt, 3);
        chk("t2_pw2_period3", if2.period_cnt, 3);
        while (done_cnt < 4 && cyc < 80) tick();
        chk("t2_cyc4", cyc, 22);
        chk("t2_first_done", first_done, 6);
        chk("t2_last_done", last_done, 21);
        chk("t2_period4", if1.period_cnt, 4);
        chk("t2_pw2_wrap", if2.period_cnt, 0);
        chk("t2_in_run", st1, 2);
        clr_mon();
        if1.stop = 1'b1;
        tick();
        if1.stop = 1'b0;
        chk("t2_stop_idle", st1, 0);
        chk("t2_stop_busy", if1.busy, 0);
        repeat (3) tick();
        chk("t2_stop_no_done", done_cnt, 0);
        chk("t2_period_hold", if1.period_cnt, 4);

        // T3: terminal 0, then terminal 15
        clr_mon();
        start_win(1'b0, 4'd0);
        wait_idle();
        chk("t3a_idle_cycle", cyc, 4);
        chk("t3a_done_cycle", last_done, 3);
        chk("t3a_en_cnt", en_cnt, 0);
        clr_mon();
        start_win(1'b0, 4'd15);
        wait_idle();
        chk("t3b_done_cycle", last_done, 18);
        chk("t3b_en_cnt", en_cnt, 15);
        chk("t3b_done_cnt", done_cnt, 1);

        // T4: start while busy, then start+stop in IDLE
        clr_mon();
        start_win(1'b0, 4'd5);
        tick();
        tick();
        if1.start = 1'b1;
        tick();
        if1.start = 1'b0;
        chk("t4_err_pulse", if1.err, 1);
        tick();
        chk("t4_err_clear", if1.err, 0);
        chk("t4_still_run", st1, 2);
        wait_idle();
        chk("t4_err_cnt", err_cnt, 1);
        chk("t4_done_cycle", last_done, 8);
        chk("t4_idle_cycle", cyc, 9);
        clr_mon();
        if1.start = 1'b1;
        if1.stop  = 1'b1;
        tick();
        if1.start = 1'b0;
        tick();
        if1.stop  = 1'b0;
        tick();
        chk("t4_startstop_idle", st1, 0);
        chk("t4_startstop_err", err_cnt, 0);
        chk("t4_startstop_period", if1.period_cnt, 1);

        // T5: counter overrun during RUN, coinciding with a start while busy
        clr_mon();
        start_win(1'b0, 4'd5);
        tick();
        tick();
        force_val = 4'd6;
        force_en  = 1'b1;
        if1.start = 1'b1;
        tick();
        if1.start = 1'b0;
        force_en  = 1'b0;
        chk("t5_idle", st1, 0);
        chk("t5_err", if1.err, 1);
        tick();
        chk("t5_err_single", if1.err, 0);
        tick();
        chk("t5_err_cnt", err_cnt, 1);
        chk("t5_no_done", done_cnt, 0);

        // T6: asynchronous reset mid-RUN and mid-RELOAD
        clr_mon();
        start_win(1'b0, 4'd5);
        tick();
        tick();
        reset_n = 1'b1;
        #1;
        chk("t6a_state", st1, 0);
        chk("t6a_busy", if1.busy, 0);
        chk("t6a_en", en1, 0);
        #1;
        reset_n = 1'b0;
        tick();
        chk("t6a_no_done", done_cnt, 0);
        clr_mon();
        start_win(1'b1, 4'd1);
        while (cyc < 8) tick();
        chk("t6b_period", if1.period_cnt, 2);
        tick();
        tick();
        chk("t6b_reload_done", if1.done, 1);
        chk("t6b_reload_clear", clr1, 1);
        reset_n = 1'b1;
        #1;
        chk("t6b_done", if1.done, 0);
        chk("t6b_clear", clr1, 0);
        chk("t6b_busy", if1.busy, 0);
        chk("t6b_period_rst", if1.period_cnt, 0);
        chk("t6b_err", if1.err, 0);
        #1;
        reset_n = 1'b0;
        tick();
        chk("never_clear_and_en", both_cnt, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
